// File: rtl/note_pkg.sv
// Shared definitions for the automatic song player: FSM states, note codes,
// ROM word layout and the beat-rate divider helper.
package note_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_PAUSE,
    S_DONE
  } state_e;

  // Note codes, same encoding as the keypad path into F_CODE
  localparam logic [3:0] NOTE_REST       = 4'd0;
  localparam logic [3:0] NOTE_LOW_FIRST  = 4'd1;
  localparam logic [3:0] NOTE_LOW_LAST   = 4'd5;
  localparam logic [3:0] NOTE_MID_FIRST  = 4'd6;
  localparam logic [3:0] NOTE_MID_LAST   = 4'd10;
  localparam logic [3:0] NOTE_HIGH_FIRST = 4'd11;
  localparam logic [3:0] NOTE_HIGH_LAST  = 4'd15;

  // Song ROM word: [7:4] duration in beat units (0 = end marker), [3:0] note
  localparam int WORD_W   = 8;
  localparam int DUR_MSB  = 7;
  localparam int DUR_LSB  = 4;
  localparam int NOTE_MSB = 3;
  localparam int NOTE_LSB = 0;

  // Clock cycles per duration unit; CLK_HZ must be an exact multiple of BEAT_HZ
  function automatic int tick_div(input int clk_hz, input int beat_hz);
    return clk_hz / beat_hz;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous song ROM, one-cycle read latency. Contents come from the SONG
// parameter, which is generated from the song memory file (word i occupies
// bits [8*i+7 : 8*i]). Sequencing lives entirely in note_sequencer.
module song_rom
  import note_pkg::*;
#(
  parameter int                               ADDR_W = 8,
  parameter logic [WORD_W*(2**ADDR_W)-1:0]    SONG   = '0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [WORD_W-1:0] data_o
);

  logic [WORD_W-1:0] data_q;

  // Registered read of the addressed song word
  always_ff @(posedge clk) begin
    data_q <= SONG[{addr_i, 3'b000} +: WORD_W];
  end

  assign data_o = data_q;

endmodule

// File: rtl/note_sequencer.sv
// Automatic song player feeding F_CODE/SPKER: walks the song ROM of
// (duration, note) words at the beat rate, silences the tail of every note
// for an articulation gap, and supports start, stop and pause/resume.
// Optional build macro NOTE_SEQ_LOOP_EN: replay the song from address 0 at
// its end marker instead of stopping in DONE.
module note_sequencer
  import note_pkg::*;
#(
  parameter int                            CLK_HZ  = 25_000_000,
  parameter int                            BEAT_HZ = 8,
  parameter int                            GAP_CYC = 250_000,
  parameter int                            ADDR_W  = 8,
  parameter logic [WORD_W*(2**ADDR_W)-1:0] SONG    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  output logic [3:0]        note_o,
  output logic              sounding_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);

  localparam int TICK_DIV = tick_div(CLK_HZ, BEAT_HZ);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  // Last sounding tick of a note's final beat unit; the gap fills the rest
  localparam logic [TW-1:0]     GAP_START = TW'(TICK_DIV - 1 - GAP_CYC);
  localparam logic [TW-1:0]     TICK_ONE  = TW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        note_q, note_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [3:0]        rem_q, rem_d;
  logic              snd_q, snd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              advance;
  logic              end_act;

  logic [WORD_W-1:0] rom_data;
  logic [3:0]        rom_dur;
  logic [3:0]        rom_note;

  song_rom #(
    .ADDR_W (ADDR_W),
    .SONG   (SONG)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  assign rom_dur  = rom_data[DUR_MSB:DUR_LSB];
  assign rom_note = rom_data[NOTE_MSB:NOTE_LSB];

  // Next-state and registered-output logic; stop beats start beats pause
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    addr_d  = addr_q;
    note_d  = note_q;
    tick_d  = tick_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    advance = 1'b0;
    end_act = 1'b0;

    if (stop_i) begin
      state_d = S_IDLE;
      ret_d   = S_IDLE;
      addr_d  = '0;
      note_d  = NOTE_REST;
      tick_d  = '0;
      rem_d   = '0;
    end else if (start_i) begin
      state_d = S_FETCH;
      ret_d   = S_IDLE;
      addr_d  = '0;
      note_d  = NOTE_REST;
      tick_d  = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (rom_dur == 4'd0) begin
            end_act = 1'b1;
          end else begin
            note_d  = rom_note;
            rem_d   = rom_dur;
            tick_d  = '0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (pause_i) begin
            ret_d   = S_PLAY;
            state_d = S_PAUSE;
          end else if (rem_q == 4'd1 && tick_q == GAP_START) begin
            if (GAP_CYC == 0) begin
              advance = 1'b1;
            end else begin
              tick_d  = tick_q + TICK_ONE;
              state_d = S_GAP;
            end
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            rem_d  = rem_q - 4'd1;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        S_GAP: begin
          if (pause_i) begin
            ret_d   = S_GAP;
            state_d = S_PAUSE;
          end else if (tick_q == TICK_LAST) begin
            advance = 1'b1;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        S_PAUSE: begin
          if (pause_i) state_d = ret_q;
        end
        default: ;
      endcase

      // Next word; stepping past the top address counts as an end marker
      if (advance) begin
        tick_d = '0;
        rem_d  = '0;
        if (addr_q == ADDR_LAST) begin
          end_act = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_FETCH;
        end
      end

      if (end_act) begin
        done_d = 1'b1;
        note_d = NOTE_REST;
        tick_d = '0;
        rem_d  = '0;
`ifdef NOTE_SEQ_LOOP_EN
        // An end marker at address 0 means an empty song: stop, don't spin
        if (state_q == S_LOAD && addr_q == '0) begin
          state_d = S_DONE;
        end else begin
          addr_d  = '0;
          state_d = S_FETCH;
        end
`else
        state_d = S_DONE;
`endif
      end
    end

    snd_d  = (state_d == S_PLAY) && (note_d != NOTE_REST);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      addr_q  <= '0;
      note_q  <= NOTE_REST;
      tick_q  <= '0;
      rem_q   <= '0;
      snd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      tick_q  <= tick_d;
      rem_q   <= rem_d;
      snd_q   <= snd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign note_o     = note_q;
  assign sounding_o = snd_q;
  assign busy_o     = busy_q;
  assign addr_o     = addr_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios with hand-computed
// expectations plus randomized start/stop/pause pulses, all outputs compared
// every cycle against a slot-position model of the player.
`timescale 1ns/1ps
module tb_note_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int BEAT_HZ = 100;
  localparam int GAP_CYC = 2;
  localparam int ADDR_W  = 2;
  localparam int TICK    = 10;
  localparam int DEPTH   = 4;
  localparam logic [31:0] SONG = 32'h0013_1025;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              pause_i = 1'b0;
  logic [3:0]        note_o;
  logic              sounding_o;
  logic              busy_o;
  logic [ADDR_W-1:0] addr_o;
  logic              done_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [7:0] rom_m [DEPTH] = '{8'h25, 8'h10, 8'h13, 8'h00};

  // Model: mode, word index, cycle position inside the current note slot
  int m_mode, m_idx, m_pos, m_note;
  bit m_paused, m_done;

  note_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .BEAT_HZ (BEAT_HZ),
    .GAP_CYC (GAP_CYC),
    .ADDR_W  (ADDR_W),
    .SONG    (SONG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .pause_i    (pause_i),
    .note_o     (note_o),
    .sounding_o (sounding_o),
    .busy_o     (busy_o),
    .addr_o     (addr_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_pos = 0; m_note = 0;
    m_paused = 1'b0; m_done = 1'b0;
  endtask

  // A slot is FETCH (pos 0), LOAD (pos 1), then dur*TICK cycles of which the
  // last GAP_CYC are silent; pause freezes pos inside the timed part only.
  task automatic model_step(input logic st, input logic sp, input logic pz);
    int  dur;
    bit  endit;
    endit  = 1'b0;
    m_done = 1'b0;
    dur    = int'(rom_m[m_idx][7:4]);
    if (sp) begin
      model_reset();
    end else if (st) begin
      model_reset();
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (m_paused) begin
        if (pz) m_paused = 1'b0;
      end else if (m_pos == 0) begin
        m_pos = 1;
      end else if (m_pos == 1) begin
        if (dur == 0) endit = 1'b1;
        else begin
          m_note = int'(rom_m[m_idx][3:0]);
          m_pos  = 2;
        end
      end else if (pz) begin
        m_paused = 1'b1;
      end else begin
        m_pos++;
        if (m_pos == 2 + dur * TICK) begin
          if (m_idx == DEPTH - 1) endit = 1'b1;
          else begin
            m_idx++;
            m_pos = 0;
          end
        end
      end
    end
    if (endit) begin
      m_done = 1'b1;
      m_note = 0;
      m_pos  = 0;
`ifdef NOTE_SEQ_LOOP_EN
      if (m_idx == 0 && dur == 0) m_mode = M_DONE;
      else begin
        m_idx  = 0;
        m_mode = M_RUN;
      end
`else
      m_mode = M_DONE;
`endif
    end
  endtask

  function automatic int exp_snd();
    int dur;
    dur = int'(rom_m[m_idx][7:4]);
    return (m_mode == M_RUN && !m_paused && m_pos >= 2 &&
            m_pos < 2 + dur * TICK - GAP_CYC && m_note != 0) ? 1 : 0;
  endfunction

  // Model advance on the active clock edge or asynchronous reset
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(start_i, stop_i, pause_i);
    end
  end

  // Per-cycle comparison, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("note", int'(note_o), m_note);
        chk("sounding", int'(sounding_o), exp_snd());
        chk("busy", int'(busy_o), (m_mode == M_RUN) ? 1 : 0);
        chk("addr", int'(addr_o), m_idx);
        chk("done", int'(done_o), int'(m_done));
      end
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_i = 1'b1;
    @(negedge clk);
    pause_i = 1'b0;
  endtask

  // Waits (bounded) for a sounding cycle; returns the cycle count waited
  task automatic wait_sound(input int bound, output int waited);
    waited = -1;
    for (int i = 1; i <= bound; i++) begin
      if (sounding_o) begin
        waited = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int first_snd, n5, n3, done_at, ndone, s, psnd, run, w;

    // Asynchronous reset at power-up
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_note", int'(note_o), 0);
    chk("rst_sounding", int'(sounding_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_addr", int'(addr_o), 0);
    chk("rst_done", int'(done_o), 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);

    // Whole song: 5 for 18, gap, rest slot, 3 for 8, done at cycle 49
    pulse_start();
    first_snd = -1; n5 = 0; n3 = 0; done_at = -1; ndone = 0;
    for (int k = 1; k <= 70; k++) begin
      if (sounding_o && first_snd < 0) first_snd = k;
      if (sounding_o && note_o == 4'd5) n5++;
      if (sounding_o && note_o == 4'd3) n3++;
      if (done_o) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      @(negedge clk);
    end
    chk("song_first_sound", first_snd, 3);
    chk("song_n3_cycles", n3, 8);
    chk("song_done_cycle", done_at, 49);
    chk("song_done_pulses", ndone, 1);
`ifdef NOTE_SEQ_LOOP_EN
    chk("song_n5_cycles", n5, 36);
    chk("song_busy_end", int'(busy_o), 1);
`else
    chk("song_n5_cycles", n5, 18);
    chk("song_busy_end", int'(busy_o), 0);
    chk("song_addr_end", int'(addr_o), 3);
`endif

    // Pause on the sixth sounding cycle (tick 5), hold 30 cycles, resume
    pulse_start();
    s = 0;
    for (int i = 0; i < 40; i++) begin
      if (sounding_o) s++;
      if (s == 6) break;
      @(negedge clk);
    end
    chk("pause_pre_count", s, 6);
    pulse_pause();
    psnd = 0;
    for (int i = 0; i < 29; i++) begin
      if (sounding_o) psnd++;
      @(negedge clk);
    end
    if (sounding_o) psnd++;
    chk("pause_silent", psnd, 0);
    chk("pause_busy", int'(busy_o), 1);
    pulse_pause();
    run = 0;
    for (int i = 0; i < 40; i++) begin
      if (!sounding_o) break;
      run++;
      @(negedge clk);
    end
    chk("resume_remaining", run, 13);

    // Now in the first gap cycle of note 5: stop aborts without done
    chk("gap_note_held", int'(note_o), 5);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("stop_busy", int'(busy_o), 0);
    chk("stop_note", int'(note_o), 0);
    chk("stop_addr", int'(addr_o), 0);
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_o || busy_o) ndone++;
      @(negedge clk);
    end
    chk("stop_quiet", ndone, 0);

    // Start and stop together while playing: stop wins
    pulse_start();
    wait_sound(10, w);
    chk("ss_reach_play", w, 3);
    start_i = 1'b1;
    stop_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("ss_busy", int'(busy_o), 0);
    chk("ss_sounding", int'(sounding_o), 0);
    repeat (5) @(negedge clk);
    pulse_start();
    wait_sound(20, w);
    chk("restart_first_sound", w, 3);
    chk("restart_note", int'(note_o), 5);
    chk("restart_addr", int'(addr_o), 0);

    // Asynchronous reset off the clock edge, mid-note
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_note", int'(note_o), 0);
    chk("arst_sounding", int'(sounding_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_addr", int'(addr_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_stay_idle", int'(busy_o), 0);

    // Randomized control pulses against the model
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      start_i = ($urandom_range(0, 199) == 0);
      stop_i  = ($urandom_range(0, 399) == 0);
      pause_i = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    pause_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Automatic song player that sits directly upstream of the note-to-tone-code stage (F_CODE) and the speaker divider (SPKER).
- Produces the same 4-bit note index the keypad path puts on display_num[3:0], plus a sounding flag that gates the beeper, in place of the key-pressed term.
- Steps through a song ROM of (duration, note) words at a fixed beat rate.
- Inserts a short articulation gap at the end of each note.
- Supports start, stop and pause/resume.

Parameters:
- CLK_HZ, 25_000_000, input clock frequency in Hz.
- BEAT_HZ, 8, duration-unit rate in Hz. TICK_DIV = CLK_HZ/BEAT_HZ cycles per unit. Integer division is required to be exact.
- GAP_CYC, 250_000, silent cycles at the tail of every note. Constraint: 0 <= GAP_CYC < TICK_DIV.
- ADDR_W, 8, song ROM address width (depth 2^ADDR_W).

Ports:
- clk  in  1  system clock (ext_clk_25m at top level).
- rst_n  in  1  asynchronous active-low reset (sys_rst_n from PLL locked).
- start_i  in  1  one-cycle pulse; start, or restart from address 0.
- stop_i  in  1  one-cycle pulse; abort to idle.
- pause_i  in  1  one-cycle pulse; toggle pause/resume.
- note_o  out  4  note index to F_CODE: 0 = rest, 1-15 = note code (same encoding as the keypad path).
- sounding_o  out  1  1 = beeper enabled (replaces ~key gating).
- busy_o  out  1  1 in any state other than IDLE/DONE.
- addr_o  out  ADDR_W  current ROM address (debug/display).
- done_o  out  1  one-cycle pulse when the song ends.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; note_o=0, sounding_o=0, busy_o=0, addr_o=0, done_o=0; all counters 0.
- ROM word (8 bits): [7:4] dur in beat units, [3:0] note. dur=0 is the end marker.
- ROM is synchronous with 1-cycle read latency.
- States: IDLE, FETCH, LOAD, PLAY, GAP, PAUSE, DONE.
- IDLE/DONE + start_i: addr=0, go to FETCH.
- FETCH: present addr; next cycle LOAD.
- LOAD: capture word.
  - dur=0: go to the end action.
  - dur!=0: note_o=word[3:0], load remaining=dur, clear tick counter, go to PLAY.
- PLAY:
  - sounding_o=(note_o!=0).
  - Tick counter runs 0..TICK_DIV-1; at wrap, remaining decrements.
  - When remaining==1 and tick==TICK_DIV-1-GAP_CYC, go to GAP.
  - If GAP_CYC=0, skip GAP: advance addr and go to FETCH.
- GAP:
  - sounding_o=0; note_o held.
  - Lasts GAP_CYC cycles, then addr+1 and FETCH.
- Note slot length is exactly dur*TICK_DIV+2 cycles (2 = FETCH+LOAD). sounding_o=0 during FETCH/LOAD.
- Address wrap: advancing from 2^ADDR_W-1 is treated as an end marker; no silent wrap.
- End action (LOOP_EN absent):
  - done_o=1 for one cycle.
  - State DONE; note_o=0, sounding_o=0.
  - addr_o holds the marker address.
- PAUSE:
  - pause_i in PLAY/GAP: go to PAUSE. Tick, remaining and addr frozen; sounding_o=0; the return state is saved.
  - pause_i in PAUSE: return to the saved state and continue from the frozen count.
  - pause_i in IDLE/FETCH/LOAD/DONE: ignored.
- stop_i in any state: next cycle IDLE, with all outputs at their reset values.
- Simultaneous pulses: priority stop_i > start_i > pause_i.
- start_i while busy: immediate restart at addr 0 via FETCH; note_o=0 and sounding_o=0 from the next cycle.
- Outputs are registered; no combinational input-to-output path.

Optional Feature:
- Macro: NOTE_SEQ_LOOP_EN.
- Defined: the end action sets addr=0 and goes to FETCH; done_o still pulses once per pass.
  - If the word at addr 0 is itself an end marker, go to DONE instead (no infinite fetch loop).
- Undefined: the end action goes to DONE as described above.

Decomposition:
- Shared package note_pkg:
  - State enum.
  - Note code constants: REST=0; low, mid and high ranges matching the keypad/F_CODE map.
  - ROM word field positions (DUR_MSB/LSB, NOTE_MSB/LSB).
  - Function computing TICK_DIV.
- Sub-module song_rom: synchronous ROM, ADDR_W address, 8-bit data, initialised from a memory file. Holds the song data only; sequencing stays in note_sequencer.

Test Plan (CLK_HZ=1000, BEAT_HZ=100 so TICK_DIV=10, GAP_CYC=2; ROM {0x25, 0x10, 0x13, 0x00}):
- Reset then start_i:
  - note_o=5 with sounding_o=1 for 18 cycles, then 2 gap cycles.
  - FETCH/LOAD, then note_o=0 with sounding_o=0 for 10 cycles.
  - note_o=3 sounding for 8 cycles.
  - done_o pulses once; DONE with busy_o=0.
- pause_i on cycle 5 of note 5: sounding_o=0 and counters frozen for 30 cycles. Second pause_i resumes; the remaining 13 sounding cycles follow exactly.
- stop_i mid-GAP: next cycle IDLE; note_o=0, addr_o=0, busy_o=0; no done_o.
- start_i and stop_i in the same cycle while PLAYing: IDLE wins. Later start_i alone restarts at addr 0 with note_o=5.
- NOTE_SEQ_LOOP_EN defined: after the marker at addr 3, done_o pulses and note 5 replays. With ROM {0x00}, go straight to DONE with one done_o pulse.
- Assert rst_n low mid-PLAY, asynchronously off a clock edge: all outputs cleared immediately. On release, stay in IDLE until start_i.
